nn_core_seq: RTL
================

# nn_core_seq

Time-multiplexed two-layer perceptron core, downstream of the CPU-side weight/input manager. It captures the flattened weight vector on a load strobe and the binary input vector on change. It evaluates hidden layer, then output layer, with one multiply-accumulate per clock and a clamped linear sigmoid. Results are presented on `o` as registered values, which the manager polls for a change.

## Interface
- `LENGHT_I`, 32, input neuron count
- `LENGHT_MID`, 8, hidden neuron count
- `LENGHT_O`, 2, output neuron count
- `WIDTH_I`, 1, input value width (unsigned)
- `WIDTH_W`, 9, weight width (signed two's complement)
- `RANGE_SIGM`, 1000, activation range; activations lie in 0..RANGE_SIGM-1
- `WIDTH_MID`, $clog2(RANGE_SIGM), hidden activation width
- `WIDTH_O`, $clog2(RANGE_SIGM), output width
- `SHIFT_O`, 8, arithmetic right shift applied to output-layer sum before activation
- `N_W`, LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O, weight count (derived)
- `clk`, input, 1, clock
- `reset`, input, 1, reset, asynchronous, active-high
- `wr`, input, 1, weight load strobe; `w_i` is valid in the same cycle
- `w_i`, input, [N_W-1:0][WIDTH_W-1:0], flattened weights
- `i_i`, input, [LENGHT_I-1:0][WIDTH_I-1:0], input neuron values
- `o`, output, [LENGHT_O-1:0][WIDTH_O-1:0], output activations, registered
- `busy`, output, 1, computation in progress
- `valid`, output, 1, one-cycle pulse when `o` is updated

## Operation
- **Weight map**
  - hidden m, input k → `w_i[m*LENGHT_I+k]`
  - output n, hidden m → `w_i[LENGHT_I*LENGHT_MID + n*LENGHT_MID + m]`
- **Internal state**: `w_reg` (weight copy), `i_snap` (input snapshot), `hid[LENGHT_MID]`, 32-bit signed `acc`, neuron and term counters.
- **Weight capture**: `w_reg <= w_i` on any clock edge with `wr=1`, in every state.
- **MAC step**: `acc += sext(weight) * zext(value)`. Values are `i_snap[k]` in layer 1 and `hid[m]` in layer 2.
- **Hidden activation**: `hid[m] = clamp(RANGE_SIGM/2 + acc, 0, RANGE_SIGM-1)`.
- **Output activation**: `clamp(RANGE_SIGM/2 + (acc >>> SHIFT_O), 0, RANGE_SIGM-1)`. The shift is arithmetic, so it floors toward −∞.
- **FSM states**: IDLE, HID, OUT, DONE.
- **IDLE**
  - Start condition: `wr=1` or `i_i != i_snap`.
  - On start: `i_snap <= i_i`, counters and `acc` cleared, next state HID.
- **HID**: per neuron, LENGHT_I MAC cycles, then 1 activation cycle that writes `hid[m]` and clears `acc`. That is LENGHT_MID*(LENGHT_I+1) cycles total, then next state OUT.
- **OUT**: per output neuron, LENGHT_MID MAC cycles, then 1 activation cycle that writes a staging register. That is LENGHT_O*(LENGHT_MID+1) cycles total. On leaving OUT, `o` is loaded from staging and the state goes to DONE.
- **DONE**: one cycle, `valid=1`, then IDLE.
- **`wr=1` in HID, OUT or DONE**: abort. Next state is HID with a fresh snapshot and cleared `acc`/counters, and no `valid` for the aborted run. `o` holds its previous value.
- **`i_i` changes outside IDLE**: ignored, because computation uses `i_snap`. The change is detected on return to IDLE and triggers a new run.
- **Simultaneous `wr` and input change in IDLE**: one start, both captured.
- **`busy`**: 1 in HID and OUT, 0 in IDLE and DONE.

## Timing
- **Reset values**: `o=0`, `valid=0`, `busy=0`, `w_reg=0`, `i_snap=0`, `hid=0`, `acc=0`, state IDLE. Asserting `reset` mid-run applies these immediately, asynchronously, and the run is lost.
- **Start edge T0**: the edge at which IDLE (or an abort) moves the FSM to HID.
- **HID** spans T0..T0+264 with defaults; OUT spans T0+264..T0+282.
- **Result**: `o` is updated and `valid` rises at edge T0+282, in general T0 + LENGHT_MID*(LENGHT_I+1) + LENGHT_O*(LENGHT_MID+1). `valid` falls at T0+283.
- **Earliest next start**: edge T0+284, since IDLE occupies at least one cycle.
- **Throughput**: one MAC per cycle; no backpressure. `o` holds until the next DONE.

## Test plan
1. **Zero weights**: reset, `wr=1` with all `w_i=0`, `i_i=0` → `valid` one cycle at T0+282, `o={500,500}`, `busy` high T0..T0+282.
2. **Linear region**
   - Stimulus: all hidden weights +1, `i_i` all 1, output-0 weights +1, output-1 weights −1.
   - Response: `hid`=532 each, `o[0]=500+(4256>>>8)=516`, `o[1]=500+(-4256>>>8)=483`.
3. **Saturation**
   - Stimulus: hidden weights +255, `i_i` all 1, output-0 weights +255, output-1 weights −256.
   - Response: `hid`=999, `o[0]=999`, `o[1]=0`.
4. **Input change mid-run**: change `i_i` at T0+100 → first `valid` at T0+282 with old-input result, second start at T0+284, second `valid` at T0+566 with new-input result.
5. **Weight reload abort**: second `wr` at T0+50 → no `valid` at T0+282, `valid` at T0+332 reflecting new weights, `o` unchanged before that.
6. **Reset mid-run**: assert `reset` at T0+150 without a clock edge → `o=0`, `busy=0`, `valid=0` immediately. After deassert with unchanged `i_i=0` and no `wr`, no `valid` appears.

Source files
------------

// File: rtl/nn_core_seq_if.sv
// nn_core_seq_if: manager-facing bus of the perceptron core (weights, inputs, results)
interface nn_core_seq_if #(
  parameter int LENGHT_I   = 32,
  parameter int LENGHT_MID = 8,
  parameter int LENGHT_O   = 2,
  parameter int WIDTH_I    = 1,
  parameter int WIDTH_W    = 9,
  parameter int RANGE_SIGM = 1000,
  parameter int WIDTH_O    = $clog2(RANGE_SIGM),
  parameter int N_W        = LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O
);
  logic                             wr;
  logic [N_W-1:0][WIDTH_W-1:0]      w_i;
  logic [LENGHT_I-1:0][WIDTH_I-1:0] i_i;
  logic [LENGHT_O-1:0][WIDTH_O-1:0] o;
  logic                             busy;
  logic                             valid;
  modport master (output wr, w_i, i_i, input o, busy, valid);
  modport slave (input wr, w_i, i_i, output o, busy, valid);
endinterface

// File: rtl/nn_core_seq.sv
// nn_core_seq: time-multiplexed two-layer perceptron, one MAC per clock, clamped linear sigmoid
module nn_core_seq #(
  parameter int LENGHT_I   = 32,
  parameter int LENGHT_MID = 8,
  parameter int LENGHT_O   = 2,
  parameter int WIDTH_I    = 1,
  parameter int WIDTH_W    = 9,
  parameter int RANGE_SIGM = 1000,
  parameter int WIDTH_MID  = $clog2(RANGE_SIGM),
  parameter int WIDTH_O    = $clog2(RANGE_SIGM),
  parameter int SHIFT_O    = 8,
  parameter int N_W        = LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O
) (
  input logic clk,
  input logic reset,
  nn_core_seq_if.slave bus
);
  localparam int TMAX = LENGHT_I > LENGHT_MID ? LENGHT_I : LENGHT_MID;
  localparam int NMAX = LENGHT_MID > LENGHT_O ? LENGHT_MID : LENGHT_O;
  localparam int TW = $clog2(TMAX+1);
  localparam int NW = $clog2(NMAX+1);
  localparam int IW = $clog2(N_W);
  localparam int KW = $clog2(LENGHT_I);
  localparam int MW = $clog2(LENGHT_MID);
  localparam int OW = $clog2(LENGHT_O);
  typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;
  state_t state, nx;
  logic [N_W-1:0][WIDTH_W-1:0]        w_reg;
  logic [LENGHT_I-1:0][WIDTH_I-1:0]   i_snap;
  logic [LENGHT_MID-1:0][WIDTH_MID-1:0] hid;
  logic [LENGHT_O-1:0][WIDTH_O-1:0]   stg, stg_nx, o_r;
  logic signed [31:0] acc, prod, sum;
  logic [31:0] val;
  logic [TW-1:0] t;
  logic [NW-1:0] n;
  logic [IW-1:0] widx;
  logic [WIDTH_O-1:0] act;
  logic start, busy_c, last_t, last_n;
  assign busy_c = state == HID || state == OUT;
  assign start = bus.wr || (state == IDLE && bus.i_i != i_snap);
  assign bus.busy = busy_c;
  assign bus.valid = state == DONE;
  assign bus.o = o_r;
  // MAC operand selection, activation and staging update for the current layer
  always_comb begin
    last_t = state == HID ? t == TW'(LENGHT_I) : t == TW'(LENGHT_MID);
    last_n = state == HID ? n == NW'(LENGHT_MID-1) : n == NW'(LENGHT_O-1);
    widx = state == HID ? IW'(n*LENGHT_I + t) : IW'(LENGHT_I*LENGHT_MID + n*LENGHT_MID + t);
    val = state == HID ? 32'(i_snap[t[KW-1:0]]) : 32'(hid[t[MW-1:0]]);
    prod = 32'($signed(w_reg[widx])) * $signed(val);
    sum = state == HID ? acc + RANGE_SIGM/2 : (acc >>> SHIFT_O) + RANGE_SIGM/2;
    act = sum < 0 ? '0 : sum >= RANGE_SIGM ? WIDTH_O'(RANGE_SIGM-1) : WIDTH_O'(sum);
    stg_nx = stg;
    if (state == OUT && last_t) stg_nx[n[OW-1:0]] = act;
  end
  // next-state: any wr (re)starts a run; input change starts one only from IDLE
  always_comb begin
    nx = start ? HID :
         state == DONE ? IDLE :
         (state == HID && last_t && last_n) ? OUT :
         (state == OUT && last_t && last_n) ? DONE : state;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nx;
  end
  // datapath: weight capture, snapshot, accumulation and activation write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_reg <= '0;
      i_snap <= '0;
      hid <= '0;
      stg <= '0;
      o_r <= '0;
      acc <= '0;
      t <= '0;
      n <= '0;
    end else begin
      if (bus.wr) w_reg <= bus.w_i;
      if (start) begin
        i_snap <= bus.i_i;
        acc <= '0;
        t <= '0;
        n <= '0;
      end else if (busy_c) begin
        if (!last_t) begin
          acc <= acc + prod;
          t <= t + 1'b1;
        end else begin
          acc <= '0;
          t <= '0;
          n <= last_n ? '0 : n + 1'b1;
          if (state == HID) hid[n[MW-1:0]] <= WIDTH_MID'(act);
          else begin
            stg <= stg_nx;
            if (last_n) o_r <= stg_nx;
          end
        end
      end
    end
  end
endmodule
